// File: rtl/sfb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sfb_pkg
// Description : Shared widths, entry record and word-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sfb_pkg;

    localparam int SFB_XLEN   = 32;
    localparam int SFB_ADDR_W = 32;
    localparam int SFB_NB     = SFB_XLEN / 8;
    localparam int SFB_OFS_W  = $clog2(SFB_NB);

    typedef struct packed {
        logic [SFB_ADDR_W-1:0] addr;
        logic [SFB_XLEN-1:0]   data;
        logic [SFB_NB-1:0]     strb;
    } sfbEntry_t;

    // Byte-offset bits are ignored: lanes are resolved through the strobes.
    function automatic logic word_match(input logic [SFB_ADDR_W-1:0] a,
                                        input logic [SFB_ADDR_W-1:0] b);
        return a[SFB_ADDR_W-1:SFB_OFS_W] == b[SFB_ADDR_W-1:SFB_OFS_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfb_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : sfb_fwd_select
// Description : Per-lane newest-first selection of forwardable store bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module sfb_fwd_select
    import sfb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int IDX_W = PTR_W + 1
) (
    input  sfbEntry_t              i_cand [DEPTH+1],
    input  logic [DEPTH:0]         i_candValid,
    input  logic [PTR_W-1:0]       i_headPtr,
    input  logic [SFB_ADDR_W-1:0]  i_ldAddr,
    input  logic [SFB_NB-1:0]      i_ldStrb,
    output logic [SFB_XLEN-1:0]    o_fwdData,
    output logic [SFB_NB-1:0]      o_fwdMask
);

    logic [IDX_W-1:0] w_slot;

    // Walk oldest (head) to newest, then the incoming store; later hits overwrite.
    always_comb begin
        o_fwdData = '0;
        o_fwdMask = '0;
        w_slot    = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            w_slot = (i == DEPTH) ? IDX_W'(DEPTH) : {1'b0, i_headPtr + PTR_W'(i)};
            if (i_candValid[w_slot] && word_match(i_cand[w_slot].addr, i_ldAddr)) begin
                for (int b = 0; b < SFB_NB; b++) begin
                    if (i_cand[w_slot].strb[b] && i_ldStrb[b]) begin
                        o_fwdData[8*b +: 8] = i_cand[w_slot].data[8*b +: 8];
                        o_fwdMask[b]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_forward_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_forward_buffer
// Description : DEPTH-entry in-order store buffer with byte-accurate forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module store_forward_buffer
    import sfb_pkg::*;
#(
    parameter  int XLEN   = SFB_XLEN,
    parameter  int ADDR_W = SFB_ADDR_W,
    parameter  int DEPTH  = 4,
    localparam int NB     = XLEN / 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [XLEN-1:0]   st_data,
    input  logic [NB-1:0]     st_strb,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [NB-1:0]     ld_strb,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN-1:0]   ld_data,
    output logic [NB-1:0]     ld_fwd_mask,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [NB-1:0]     mem_wstrb,
    input  logic              drain_req,
    output logic              drained,
    output logic [CNT_W-1:0]  count
);

    sfbEntry_t        r_entries [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_fwdData;
    logic [NB-1:0]    r_fwdMask;

    logic             w_push;
    logic             w_pop;
    sfbEntry_t        w_head;
    sfbEntry_t        w_cand [DEPTH+1];
    logic [DEPTH:0]   w_candValid;
    logic [XLEN-1:0]  w_selData;
    logic [NB-1:0]    w_selMask;

    // Ready depends on occupancy only, so a same-cycle pop never frees a full buffer.
    assign st_ready   = (r_count != CNT_W'(DEPTH));
    assign w_push     = st_valid & st_ready;
    assign mem_wvalid = r_valid[r_rdPtr];
    assign w_pop      = mem_wvalid & mem_wready;

    assign w_head     = mem_wvalid ? r_entries[r_rdPtr] : '0;
    assign mem_waddr  = w_head.addr;
    assign mem_wdata  = w_head.data;
    assign mem_wstrb  = w_head.strb;

    assign count      = r_count;
    assign drained    = drain_req & (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_wrPtr] <= '{addr: st_addr, data: st_data, strb: st_strb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cand
            assign w_cand[i] = r_entries[i];
        end
    endgenerate
    assign w_cand[DEPTH] = '{addr: st_addr, data: st_data, strb: st_strb};
    assign w_candValid   = {w_push, r_valid};

    sfb_fwd_select #(
        .DEPTH (DEPTH)
    ) u_fwdSelect (
        .i_cand      (w_cand),
        .i_candValid (w_candValid),
        .i_headPtr   (r_rdPtr),
        .i_ldAddr    (ld_addr),
        .i_ldStrb    (ld_strb),
        .o_fwdData   (w_selData),
        .o_fwdMask   (w_selMask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwdData <= '0;
            r_fwdMask <= '0;
        end else if (ld_valid) begin
            r_fwdData <= w_selData;
            r_fwdMask <= w_selMask;
        end else begin
            r_fwdData <= '0;
            r_fwdMask <= '0;
        end
    end

    generate
        for (genvar b = 0; b < NB; b++) begin : g_lane
            assign ld_data[8*b +: 8] = r_fwdMask[b] ? r_fwdData[8*b +: 8] : mem_rdata[8*b +: 8];
        end
    endgenerate
    assign ld_fwd_mask = r_fwdMask;

endmodule
`default_nettype wire

// File: tb/tb_store_forward_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_forward_buffer
// Description : Table and sequence driven bench for store_forward_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_forward_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_strb;
    logic [31:0] mem_rdata;
    logic [31:0] ld_data;
    logic [3:0]  ld_fwd_mask;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        drain_req;
    logic        drained;
    logic [2:0]  count;

    store_forward_buffer #(
        .XLEN   (32),
        .ADDR_W (32),
        .DEPTH  (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_strb     (st_strb),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_strb     (ld_strb),
        .mem_rdata   (mem_rdata),
        .ld_data     (ld_data),
        .ld_fwd_mask (ld_fwd_mask),
        .mem_wvalid  (mem_wvalid),
        .mem_wready  (mem_wready),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .drain_req   (drain_req),
        .drained     (drained),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stV;
        logic [31:0] stA;
        logic [31:0] stD;
        logic [3:0]  stS;
        logic        ldV;
        logic [31:0] ldA;
        logic [3:0]  ldS;
        logic        wr;
        logic [31:0] rdata;
        logic [31:0] expD;
        logic [3:0]  expM;
        logic [2:0]  expC;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] expD;
        logic [3:0]  expM;
        logic [2:0]  expC;
    } sbItem_t;

    localparam int NV = 17;

    vec_t        vecs [NV];
    sbItem_t     sb [$];
    logic [63:0] mQ [$];
    int          nVec = 0;
    int          nErr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle against the write-port model: drive, check at negedge, update at posedge.
    task automatic tick(input logic stv, input logic [31:0] a, input logic [31:0] d, input logic wr);
        logic pushOk;
        logic popOk;
        st_valid   = stv;
        st_addr    = a;
        st_data    = d;
        st_strb    = 4'hF;
        mem_wready = wr;
        ld_valid   = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        chk("st_ready",   32'(st_ready),   32'(mQ.size() < 4));
        chk("count",      32'(count),      32'(mQ.size()));
        chk("mem_wvalid", 32'(mem_wvalid), 32'(mQ.size() > 0));
        chk("drained",    32'(drained),    32'(drain_req && mQ.size() == 0));
        if (mQ.size() > 0) begin
            chk("mem_waddr", mem_waddr, mQ[0][63:32]);
            chk("mem_wdata", mem_wdata, mQ[0][31:0]);
        end else begin
            chk("mem_waddr_idle", mem_waddr, 32'h0);
            chk("mem_wdata_idle", mem_wdata, 32'h0);
        end
        pushOk = stv && (mQ.size() < 4);
        popOk  = wr && (mQ.size() > 0);
        @(posedge clk);
        #1;
        if (popOk)  void'(mQ.pop_front());
        if (pushOk) mQ.push_back({a, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        vec_t    v;
        sbItem_t e;
        int      issued;
        int      cyc;
        logic    acc;

        vecs[0]  = '{1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A0000, 32'h5A5A0000, 4'h0, 3'd1};
        vecs[1]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000, 4'hF, 1'b0, 32'h00000000, 32'hDEADBEEF, 4'hF, 3'd1};
        vecs[2]  = '{1'b1, 32'h2000, 32'h11223344, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A0002, 32'h5A5A0002, 4'h0, 3'd2};
        vecs[3]  = '{1'b1, 32'h2002, 32'hAABB0000, 4'hC, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A0003, 32'h5A5A0003, 4'h0, 3'd3};
        vecs[4]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2000, 4'hF, 1'b0, 32'h55667788, 32'hAABB3344, 4'hF, 3'd3};
        vecs[5]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h5A5A0005, 32'h5A5A0005, 4'h0, 3'd2};
        vecs[6]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2000, 4'hF, 1'b1, 32'h00000000, 32'hAABB3344, 4'hF, 3'd1};
        vecs[7]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2000, 4'hF, 1'b1, 32'h55667788, 32'hAABB7788, 4'hC, 3'd0};
        vecs[8]  = '{1'b1, 32'h3000, 32'h000000CC, 4'h1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A0008, 32'h5A5A0008, 4'h0, 3'd1};
        vecs[9]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h3000, 4'hF, 1'b0, 32'h12345678, 32'h123456CC, 4'h1, 3'd1};
        vecs[10] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h3000, 4'hE, 1'b0, 32'h12345678, 32'h12345678, 4'h0, 3'd1};
        vecs[11] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h3004, 4'hF, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 4'h0, 3'd1};
        vecs[12] = '{1'b1, 32'h4000, 32'h0F0F0F0F, 4'hF, 1'b1, 32'h4000, 4'hF, 1'b0, 32'h00000000, 32'h0F0F0F0F, 4'hF, 3'd2};
        vecs[13] = '{1'b1, 32'h4000, 32'h000000FF, 4'h1, 1'b1, 32'h4000, 4'hF, 1'b0, 32'h00000000, 32'h0F0F0FFF, 4'hF, 3'd3};
        vecs[14] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h5A5A000E, 32'h5A5A000E, 4'h0, 3'd2};
        vecs[15] = '{1'b1, 32'h5000, 32'h01020304, 4'hF, 1'b1, 32'h4000, 4'hF, 1'b1, 32'h00000000, 32'h0F0F0FFF, 4'hF, 3'd2};
        vecs[16] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h5000, 4'h3, 1'b0, 32'hFFFFFFFF, 32'hFFFF0304, 4'h3, 3'd2};

        rst        = 1'b1;
        st_valid   = 1'b0;
        st_addr    = 32'h0;
        st_data    = 32'h0;
        st_strb    = 4'h0;
        ld_valid   = 1'b0;
        ld_addr    = 32'h0;
        ld_strb    = 4'h0;
        mem_rdata  = 32'h0;
        mem_wready = 1'b0;
        drain_req  = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_count",      32'(count),       32'h0);
        chk("rst_st_ready",   32'(st_ready),    32'h1);
        chk("rst_mem_wvalid", 32'(mem_wvalid),  32'h0);
        chk("rst_mem_waddr",  mem_waddr,        32'h0);
        chk("rst_mem_wdata",  mem_wdata,        32'h0);
        chk("rst_mem_wstrb",  32'(mem_wstrb),   32'h0);
        chk("rst_ld_data",    ld_data,          32'h0);
        chk("rst_ld_mask",    32'(ld_fwd_mask), 32'h0);
        chk("rst_drained_hi", 32'(drained),     32'h1);
        drain_req = 1'b0;
        #1;
        chk("rst_drained_lo", 32'(drained),     32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table phase: load results are scored one cycle after issue
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) v = vecs[i];
            else        v = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0};
            st_valid   = v.stV;
            st_addr    = v.stA;
            st_data    = v.stD;
            st_strb    = v.stS;
            ld_valid   = v.ldV;
            ld_addr    = v.ldA;
            ld_strb    = v.ldS;
            mem_wready = v.wr;
            mem_rdata  = (sb.size() > 0) ? sb[0].rdata : 32'h0;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("vec%0d_ld_data", i - 1), ld_data,          e.expD);
                chk($sformatf("vec%0d_ld_mask", i - 1), 32'(ld_fwd_mask), 32'(e.expM));
                chk($sformatf("vec%0d_count",   i - 1), 32'(count),       32'(e.expC));
            end
            if (i < NV) sb.push_back('{v.rdata, v.expD, v.expM, v.expC});
            @(posedge clk);
            #1;
        end

        // Drain with fence: two entries remain, wready toggles 1,0,1
        mQ.push_back({32'h4000, 32'h000000FF});
        mQ.push_back({32'h5000, 32'h01020304});
        drain_req = 1'b1;
        chk("drain_head_wstrb", 32'(mem_wstrb), 32'h1);
        tick(1'b0, 32'h0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 32'h0, 1'b0);
        drain_req = 1'b0;
        tick(1'b0, 32'h0, 32'h0, 1'b0);

        // Fill to full, refused push, pop while full does not admit the store
        for (int k = 0; k < 4; k++) tick(1'b1, 32'h6000 + 32'(4 * k), 32'h100 + 32'(k), 1'b0);
        tick(1'b1, 32'h7000, 32'h00000BAD, 1'b0);
        tick(1'b1, 32'h7000, 32'h00000BAD, 1'b1);
        tick(1'b0, 32'h0, 32'h0, 1'b0);

        // Wrap: ten stores drained in order with intermittent wready
        issued = 0;
        cyc    = 0;
        while ((issued < 10 || mQ.size() > 0) && cyc < 80) begin
            acc = (issued < 10) && (mQ.size() < 4);
            tick(issued < 10, 32'h8000 + 32'(4 * issued), 32'hC0DE0000 + 32'(issued), (cyc % 3) != 0);
            if (acc) issued++;
            cyc++;
        end

        // Asynchronous reset with entries pending
        tick(1'b1, 32'h9000, 32'h11111111, 1'b0);
        tick(1'b1, 32'h9004, 32'h22222222, 1'b0);
        st_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count",      32'(count),      32'h0);
        chk("async_rst_mem_wvalid", 32'(mem_wvalid), 32'h0);
        chk("async_rst_st_ready",   32'(st_ready),   32'h1);
        @(negedge clk);
        rst = 1'b0;
        mQ.delete();
        @(posedge clk);
        #1;
        tick(1'b0, 32'h0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_forward_buffer.md
Name: store_forward_buffer

Overview:
- Parametrised successor to the pipeline's single-entry load-after-store bypass.
- Holds up to DEPTH committed stores in age order and drains them to data memory through a valid/ready write port.
- Forwards byte-accurate store data to any load that overlaps a pending store.
- Sits between the MEM stage and the synchronous data memory. Load data is returned one cycle after the lookup, matching memory read latency.

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 32, byte address width.
- DEPTH, 4, number of store entries; power of two, minimum 2.
- NB, XLEN/8, byte lanes (derived, not overridable).
- OFS_W, log2(NB), byte-offset bits ignored for word matching (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  MEM stage presents a committed store.
- st_ready  out  1  buffer can accept a store (~full).
- st_addr  in  ADDR_W  store byte address.
- st_data  in  XLEN  store data, already lane-aligned.
- st_strb  in  NB  byte enables.
- ld_valid  in  1  MEM stage issues a load lookup this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_strb  in  NB  bytes the load needs.
- mem_rdata  in  XLEN  memory read data, valid the cycle after ld_valid.
- ld_data  out  XLEN  merged load data, valid the cycle after ld_valid.
- ld_fwd_mask  out  NB  registered: which lanes of ld_data came from the buffer.
- mem_wvalid  out  1  head entry is valid.
- mem_wready  in  1  memory accepts the head write.
- mem_waddr  out  ADDR_W  head address.
- mem_wdata  out  XLEN  head data.
- mem_wstrb  out  NB  head byte enables.
- drain_req  in  1  fence; level-sensitive.
- drained  out  1  drain_req & empty.
- count  out  log2(DEPTH)+1  occupancy.

Behaviour:
- Reset:
  - Pointers, count, fwd registers and entry valids clear to 0.
  - Outputs: st_ready=1, mem_wvalid=0, mem_w* = 0, ld_data=0, ld_fwd_mask=0, count=0, drained=drain_req.
  - Reset mid-drain discards all entries; there is no partial write-back guarantee.
- Storage: circular FIFO with wr_ptr, rd_ptr and count. Push when st_valid & st_ready; pop when mem_wvalid & mem_wready.
- Push and pop in the same cycle: count is unchanged.
- Full: st_ready=0 even if a pop occurs that cycle. No combinational ready path from mem_wready.
- Empty: mem_wvalid=0 and mem_w* held at 0.
- Pointers wrap modulo DEPTH.
- mem_w* are driven directly from the head entry (combinational from registers). The head is stable while mem_wvalid & ~mem_wready.
- Word match: entry address and ld_addr are equal on bits [ADDR_W-1:OFS_W].
- Per-lane priority, newest wins:
  1. The store being pushed this cycle (st_valid & st_ready), if it matches with st_strb[b].
  2. Then valid entries from tail-1 down to head.
  - An entry being popped this cycle still participates.
- Lane b is forwarded iff ld_strb[b] and some candidate matches with strb[b]=1.
- Cycle N (ld_valid): register the fwd byte values and the mask.
- Cycle N+1:
  - ld_data lane b = fwd_mask[b] ? fwd_byte[b] : mem_rdata lane b.
  - ld_fwd_mask = registered mask.
- With ld_valid=0, the fwd registers are cleared, so ld_data = mem_rdata.
- Loads never stall: memory holds every byte not covered by a pending store, so merging is always correct.
- Multiple pending stores to the same word each drain separately, in order; no coalescing.
- drained is combinational: drain_req & (count==0).
- No arithmetic beyond the pointer and count increments. count never exceeds DEPTH.

Decomposition:
- Shared package (sfb_pkg) holds:
  - XLEN/ADDR_W defaults.
  - Derived NB and OFS_W.
  - The entry struct {addr, data, strb}.
  - A word_match function.
- One sub-module, sfb_fwd_select:
  - Combinational per-lane newest-first priority select.
  - Inputs: DEPTH+1 candidates and the age order.
  - Outputs: byte values and mask.
- FIFO pointers stay in the top level.

Test Plan:
- Reset, then store 0x1000/0xDEADBEEF/strb 1111 with mem_wready=0; load 0x1000 strb 1111 with mem_rdata=0 -> next cycle ld_data=0xDEADBEEF, ld_fwd_mask=1111, count=1.
- Stores 0x2000 data 0x11223344 strb 1111, then 0x2002 data 0xAABB0000 strb 1100; load 0x2000, mem_rdata=0x55667788 -> ld_data=0xAABB3344, mask=1111.
- Store 0x3000 data 0x000000CC strb 0001; load 0x3000 strb 1111, mem_rdata=0x12345678 -> ld_data=0x123456CC, mask=0001.
- Fill DEPTH=4 stores with mem_wready=0 -> st_ready=0, count=4. Push attempt is ignored. Assert mem_wready for one cycle -> head popped, count=3, st_ready=1 the next cycle; wrap check over 10 stores drained in order.
- Store and same-word load in the same cycle (0x4000, data 0x0F0F0F0F) -> ld_data=0x0F0F0F0F. Simultaneous push and pop at count=2 -> count stays 2.
- drain_req=1 with 2 entries and mem_wready toggling 1,0,1 -> drained rises the cycle after the second pop. Assert rst mid-stream -> count=0, mem_wvalid=0 immediately.
